// File: rtl/ew_pkg.sv
// Shared definitions for the edge-walker attribute stepper: default widths,
// FSM state encoding and signed saturation limits.
package ew_pkg;

  localparam int unsigned EW_ATT_W  = 32;
  localparam int unsigned EW_LINE_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } ew_state_e;

  // s15.16 saturation limits at the default attribute width
  localparam logic [EW_ATT_W-1:0] EW_ATT_MAX = {1'b0, {(EW_ATT_W-1){1'b1}}};
  localparam logic [EW_ATT_W-1:0] EW_ATT_MIN = {1'b1, {(EW_ATT_W-1){1'b0}}};

endpackage

// File: rtl/ew_att_acc.sv
// Attribute accumulator: holds the running attribute and its per-line slope.
// EW_ATT_STEP_CLAMP_EN selects a signed saturating add instead of wrapping.
module ew_att_acc
  import ew_pkg::*;
#(
  parameter int unsigned ATT_W = EW_ATT_W
) (
  input  logic             gclk,
  input  logic             reset_l,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [ATT_W-1:0] i_att,
  input  logic [ATT_W-1:0] i_de,
  output logic [ATT_W-1:0] o_acc
);

  logic [ATT_W-1:0] r_acc;
  logic [ATT_W-1:0] r_de_s;
  logic [ATT_W-1:0] w_sum;

`ifdef EW_ATT_STEP_CLAMP_EN
  localparam logic [ATT_W-1:0] SAT_MAX = {1'b0, {(ATT_W-1){1'b1}}};
  localparam logic [ATT_W-1:0] SAT_MIN = {1'b1, {(ATT_W-1){1'b0}}};

  logic [ATT_W-1:0] w_raw;
  logic             w_ovf;

  // Overflow only when both operands share a sign the result does not
  assign w_raw = r_acc + r_de_s;
  assign w_ovf = (r_acc[ATT_W-1] == r_de_s[ATT_W-1]) &&
                 (w_raw[ATT_W-1] != r_acc[ATT_W-1]);
  assign w_sum = w_ovf ? (r_acc[ATT_W-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
  assign w_sum = r_acc + r_de_s;
`endif

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      r_acc  <= '0;
      r_de_s <= '0;
    end else if (i_load) begin
      r_acc  <= i_att;
      r_de_s <= i_de;
    end else if (i_step) begin
      r_acc  <= w_sum;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/ew_att_step.sv
// Edge-walker attribute stepper: emits one attribute per scanline to the span
// buffer. Optional saturation via EW_ATT_STEP_CLAMP_EN (see ew_att_acc).
module ew_att_step
  import ew_pkg::*;
#(
  parameter int unsigned ATT_W  = EW_ATT_W,
  parameter int unsigned LINE_W = EW_LINE_W
) (
  input  logic              gclk,
  input  logic              reset_l,
  input  logic              start,
  input  logic [ATT_W-1:0]  att_d_in,
  input  logic [ATT_W-1:0]  de,
  input  logic [LINE_W-1:0] num_lines,
  input  logic              ew_stall_attr,
  input  logic              span_ready,
  output logic              span_valid,
  output logic [ATT_W-1:0]  span_att,
  output logic              span_last,
  output logic              busy,
  output logic              done
);

  ew_state_e         r_state;
  ew_state_e         w_state_nxt;
  logic [LINE_W-1:0] r_cnt;
  logic [LINE_W-1:0] w_cnt_nxt;
  logic              r_span_valid;
  logic              r_span_last;
  logic              r_busy;
  logic              r_done;
  logic              w_load;
  logic              w_step;
  logic              w_accept;
  logic [ATT_W-1:0]  w_acc;

  assign w_accept = r_span_valid & span_ready & ~ew_stall_attr;

  ew_att_acc #(
    .ATT_W (ATT_W)
  ) u_acc (
    .gclk    (gclk),
    .reset_l (reset_l),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_att   (att_d_in),
    .i_de    (de),
    .o_acc   (w_acc)
  );

  // State, line counter and registered handshake outputs
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_span_valid <= 1'b0;
      r_span_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_span_valid <= (w_state_nxt == EMIT);
      r_span_last  <= (w_state_nxt == EMIT) && (w_cnt_nxt == LINE_W'(1));
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (w_state_nxt == FIN);
    end
  end

  // Next state and accumulator control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (num_lines != '0) begin
            w_load      = 1'b1;
            w_cnt_nxt   = num_lines;
            w_state_nxt = EMIT;
          end else begin
            w_state_nxt = FIN;
          end
        end
      end
      EMIT: begin
        if (w_accept) begin
          w_step    = 1'b1;
          w_cnt_nxt = r_cnt - LINE_W'(1);
          if (r_cnt == LINE_W'(1)) begin
            w_state_nxt = FIN;
          end
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign span_valid = r_span_valid;
  assign span_att   = w_acc;
  assign span_last  = r_span_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_ew_att_step.sv
// Self-checking bench for ew_att_step: directed vector table, hand-written
// corner sequences and randomized primitives against an arithmetic model.
module tb_ew_att_step;

  logic        gclk;
  logic        reset_l;
  logic        start;
  logic [31:0] att_d_in;
  logic [31:0] de;
  logic [11:0] num_lines;
  logic        ew_stall_attr;
  logic        span_ready;
  logic        span_valid;
  logic [31:0] span_att;
  logic        span_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  ew_att_step dut (
    .gclk          (gclk),
    .reset_l       (reset_l),
    .start         (start),
    .att_d_in      (att_d_in),
    .de            (de),
    .num_lines     (num_lines),
    .ew_stall_attr (ew_stall_attr),
    .span_ready    (span_ready),
    .span_valid    (span_valid),
    .span_att      (span_att),
    .span_last     (span_last),
    .busy          (busy),
    .done          (done)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    logic [31:0] att;
    logic [31:0] d;
    int          n;
    int          mode;
    bit          inject;
    logic [31:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Next line value from the arithmetic definition of the accumulate
  function automatic logic [31:0] step_model(input logic [31:0] a, input logic [31:0] d);
`ifdef EW_ATT_STEP_CLAMP_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(d));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
`else
    return a + d;
`endif
  endfunction

  // Drives one primitive from IDLE and checks every cycle until IDLE again.
  // mode 0: always ready; 1: random ready/stall; 2: 2 cycles not ready then
  // 2 cycles stalled on the first line.
  task automatic run_prim(input logic [31:0] att, input logic [31:0] d, input int n,
                          input int mode, input bit inject, output logic [31:0] last_att);
    logic [31:0] exp_v;
    int          k;
    int          c;
    int          guard;
    bit          acc;
    start = 1'b1; att_d_in = att; de = d; num_lines = 12'(n);
    span_ready = 1'b0; ew_stall_attr = 1'b0;
    @(negedge gclk);
    start = 1'b0; att_d_in = $urandom; de = $urandom; num_lines = 12'($urandom);
    exp_v = att; k = 0; c = 0; guard = 0; last_att = '0;
    while (k < n) begin
      chk("span_valid", 32'(span_valid), 32'd1);
      chk("span_att", span_att, exp_v);
      chk("span_last", 32'(span_last), 32'(k == n - 1));
      chk("busy_emit", 32'(busy), 32'd1);
      chk("done_emit", 32'(done), 32'd0);
      if (k == n - 1) last_att = span_att;
      case (mode)
        0: begin span_ready = 1'b1; ew_stall_attr = 1'b0; end
        1: begin
          span_ready    = ($urandom_range(0, 3) != 0);
          ew_stall_attr = ($urandom_range(0, 4) == 0);
        end
        default: begin
          span_ready    = (k != 0) || (c >= 2);
          ew_stall_attr = (k == 0) && (c >= 2) && (c < 4);
        end
      endcase
      if (inject && guard == 1) begin
        start = 1'b1; att_d_in = 32'hDEAD_0000; de = 32'h0000_0001; num_lines = 12'd7;
      end
      acc = span_ready && !ew_stall_attr;
      @(negedge gclk);
      start = 1'b0;
      guard++; c++;
      if (acc) begin
        exp_v = step_model(exp_v, d);
        k++;
        c = 0;
      end
      if (guard > 200) begin
        errors++;
        $display("FAIL timeout: line %0d of %0d not accepted within 200 cycles", k, n);
        break;
      end
    end
    span_ready = 1'b0; ew_stall_attr = 1'b0;
    chk("done_fin", 32'(done), 32'd1);
    chk("busy_fin", 32'(busy), 32'd1);
    chk("valid_fin", 32'(span_valid), 32'd0);
    @(negedge gclk);
    chk("done_idle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("valid_idle", 32'(span_valid), 32'd0);
  endtask

  vec_t        vecs[6];
  logic [31:0] last;
  logic [31:0] ra;
  logic [31:0] rd;

  initial begin
    reset_l = 1'b0; start = 1'b0; att_d_in = '0; de = '0; num_lines = '0;
    ew_stall_attr = 1'b0; span_ready = 1'b0;

    vecs[0] = '{32'h0001_0000, 32'h0000_8000, 3, 0, 1'b0, 32'h0002_0000};
    vecs[1] = '{32'h0001_0000, 32'h0000_8000, 3, 2, 1'b0, 32'h0002_0000};
    vecs[2] = '{32'h0001_0000, 32'h0000_8000, 3, 2, 1'b1, 32'h0002_0000};
`ifdef EW_ATT_STEP_CLAMP_EN
    vecs[3] = '{32'h7FFF_0000, 32'h0002_0000, 2, 0, 1'b0, 32'h7FFF_FFFF};
    vecs[4] = '{32'h8001_0000, 32'hFFFE_0000, 2, 0, 1'b0, 32'h8000_0000};
`else
    vecs[3] = '{32'h7FFF_0000, 32'h0002_0000, 2, 0, 1'b0, 32'h8001_0000};
    vecs[4] = '{32'h8001_0000, 32'hFFFE_0000, 2, 0, 1'b0, 32'h7FFF_0000};
`endif
    vecs[5] = '{32'h0001_0000, 32'hFFFF_8000, 4, 1, 1'b0, 32'hFFFF_8000};

    repeat (3) @(negedge gclk);
    chk("rst_valid", 32'(span_valid), 32'd0);
    chk("rst_att", span_att, 32'd0);
    chk("rst_last", 32'(span_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_l = 1'b1;
    @(negedge gclk);

    for (int i = 0; i < 6; i++) begin
      run_prim(vecs[i].att, vecs[i].d, vecs[i].n, vecs[i].mode, vecs[i].inject, last);
      chk($sformatf("vec%0d_last", i), last, vecs[i].exp_last);
    end

    // Zero lines: done at N+1, busy for exactly one cycle, nothing emitted
    start = 1'b1; att_d_in = 32'h1234_0000; de = 32'h1; num_lines = 12'd0;
    @(negedge gclk);
    start = 1'b0;
    chk("zero_valid", 32'(span_valid), 32'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    @(negedge gclk);
    chk("zero_done2", 32'(done), 32'd0);
    chk("zero_busy2", 32'(busy), 32'd0);
    chk("zero_valid2", 32'(span_valid), 32'd0);

    // Asynchronous reset in the middle of EMIT
    start = 1'b1; att_d_in = 32'h0005_0000; de = 32'h0001_0000; num_lines = 12'd6;
    @(negedge gclk);
    start = 1'b0; span_ready = 1'b1;
    @(negedge gclk);
    #2 reset_l = 1'b0;
    #1;
    chk("arst_valid", 32'(span_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_last", 32'(span_last), 32'd0);
    span_ready = 1'b0;
    @(negedge gclk);
    reset_l = 1'b1;
    @(negedge gclk);
    chk("arst_nodone", 32'(done), 32'd0);
    run_prim(32'h0003_0000, 32'h0000_4000, 2, 0, 1'b0, last);
    chk("arst_fresh_last", last, 32'h0003_4000);

    // Randomized primitives against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rd = (i % 3 == 0) ? $urandom : 32'($signed(12'($urandom)) <<< 8);
      run_prim(ra, rd, $urandom_range(1, 9), 1, (i % 5 == 0), last);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
